// File: rtl/stopwatch_ctrl_if.sv
// Button/display bundle of the stopwatch controller: debounced button pulses in,
// BCD display word and status flags out.
interface stopwatch_ctrl_if;
  logic        btn_start_stop;
  logic        btn_lap;
  logic        btn_clear;
  logic [23:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        wrap;

  modport master (
    output btn_start_stop, btn_lap, btn_clear,
    input  disp_bcd, running, lap_active, wrap
  );

  modport slave (
    input  btn_start_stop, btn_lap, btn_clear,
    output disp_bcd, running, lap_active, wrap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronises the 100 Hz tick, sequences an MM:SS.cc BCD
// counter with start/stop/lap/clear, and shows either the live count or a lap value.
module stopwatch_ctrl #(
  parameter int unsigned MINUTE_LIMIT = 59
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_in,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } bcd_t;

  localparam logic [3:0] LIM_T = 4'(MINUTE_LIMIT / 10);
  localparam logic [3:0] LIM_U = 4'(MINUTE_LIMIT % 10);

  logic   s1, s2, s3;
  logic   tick_evt;
  state_e state, state_nxt;
  bcd_t   count, count_inc, lap_reg;
  logic   do_ss, do_clear, do_lap;
  logic   counting, at_limit, latch_lap, zero_all;
  logic   wrap_q;

  // NOTE: non-blocking assignments make s1->s2->s3 a real shift register;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_evt = s2 & ~s3;

  // start_stop beats clear, clear beats lap; losers are simply dropped.
  assign do_ss    = sw.btn_start_stop;
  assign do_clear = sw.btn_clear & ~sw.btn_start_stop;
  assign do_lap   = sw.btn_lap & ~sw.btn_start_stop & ~sw.btn_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // branch can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    latch_lap = 1'b0;
    zero_all  = 1'b0;
    case (state)
      IDLE:  if (do_ss) state_nxt = RUN;
      RUN: begin
        if (do_ss) state_nxt = PAUSE;
        else if (do_lap) begin
          state_nxt = LAP;
          latch_lap = 1'b1;
        end
      end
      LAP: begin
        if (do_ss)         state_nxt = PAUSE;
        else if (do_clear) state_nxt = RUN;
        else if (do_lap)   latch_lap = 1'b1;
      end
      PAUSE: begin
        if (do_ss) state_nxt = RUN;
        else if (do_clear) begin
          state_nxt = IDLE;
          zero_all  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sw.running    = (state == RUN) || (state == LAP);
    sw.lap_active = (state == LAP);
    sw.disp_bcd   = (state == LAP) ? lap_reg : count;
  end

  assign sw.wrap  = wrap_q;
  assign counting = tick_evt && ((state == RUN) || (state == LAP));

  // Ripple BCD increment; the all-digits-max check wraps the whole count to zero.
  always_comb begin
    count_inc = count;
    at_limit  = (count.min_t == LIM_T) && (count.min_u == LIM_U) &&
                (count.sec_t == 4'd5) && (count.sec_u == 4'd9) &&
                (count.cs_t == 4'd9) && (count.cs_u == 4'd9);
    if (at_limit) begin
      count_inc = '0;
    end else if (count.cs_u != 4'd9) begin
      count_inc.cs_u = count.cs_u + 4'd1;
    end else begin
      count_inc.cs_u = 4'd0;
      if (count.cs_t != 4'd9) begin
        count_inc.cs_t = count.cs_t + 4'd1;
      end else begin
        count_inc.cs_t = 4'd0;
        if (count.sec_u != 4'd9) begin
          count_inc.sec_u = count.sec_u + 4'd1;
        end else begin
          count_inc.sec_u = 4'd0;
          if (count.sec_t != 4'd5) begin
            count_inc.sec_t = count.sec_t + 4'd1;
          end else begin
            count_inc.sec_t = 4'd0;
            if (count.min_u != 4'd9) begin
              count_inc.min_u = count.min_u + 4'd1;
            end else begin
              count_inc.min_u = 4'd0;
              count_inc.min_t = count.min_t + 4'd1;
            end
          end
        end
      end
    end
  end

  // lap_reg samples count before this cycle's increment lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      lap_reg <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= counting && at_limit;
      if (zero_all) begin
        count   <= '0;
        lap_reg <= '0;
      end else begin
        if (counting)  count   <= count_inc;
        if (latch_lap) lap_reg <= count;
      end
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller that runs off the 100 Hz output of the frequency divider. The 100 Hz square wave is synchronised into the system clock domain and turned into one-cycle count events. A start/stop/lap/clear state machine then sequences a six-digit BCD time counter (MM:SS.cc). The block drives the display path with either the live count or a frozen lap value.

## Interface
Parameters:
- MINUTE_LIMIT, 59: highest minute value (0–99) before the count wraps to zero.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- tick_in  input  1  100 Hz square wave from the divider; asynchronous to clk's logic; high and low phases each ≥2 clk cycles
- btn_start_stop  input  1  debounced one-cycle pulse
- btn_lap  input  1  debounced one-cycle pulse
- btn_clear  input  1  debounced one-cycle pulse
- disp_bcd  output  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each
- running  output  1  high in RUN or LAP
- lap_active  output  1  high in LAP; disp_bcd shows the lap register
- wrap  output  1  one-cycle pulse when the count rolls over from MINUTE_LIMIT:59.99

## Operation
- Tick synchroniser:
  - tick_in passes through flops s1 and s2, then an edge flop s3.
  - tick_evt = s2 & ~s3.
  - Exactly one event per tick_in rising edge, regardless of high-phase length.
- Counter advances on tick_evt only when the current state is RUN or LAP. The count is decided by the state register before any transition in the same cycle.
- Counter digits:
  - cs_u 0–9, cs_t 0–9, sec_u 0–9, sec_t 0–5, min_u 0–9, min_t 0–9.
  - Each digit carries into the next when it wraps.
  - minutes = 10·min_t + min_u, capped at MINUTE_LIMIT.
  - At MINUTE_LIMIT:59.99, a tick_evt sets all digits to 0 and asserts wrap for that cycle.
- States IDLE, RUN, LAP, PAUSE. Transitions:
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → PAUSE. lap → LAP, and the current count is copied into lap_reg. clear is ignored.
  - LAP: start_stop → PAUSE, and the display returns to live. lap re-latches lap_reg with the current count and the state stays LAP. clear → RUN (lap release).
  - PAUSE: start_stop → RUN. clear → IDLE, and the count and lap_reg are zeroed. lap is ignored.
- Simultaneous button pulses: priority start_stop > clear > lap. Lower-priority pulses in that cycle are dropped.
- lap latch coinciding with a tick_evt: lap_reg captures the pre-increment count.
- Outputs:
  - disp_bcd = lap_active ? lap_reg : count. This is a combinational mux of registers.
  - running and lap_active are decoded from the state register.
- Reset (asserted at any time, including mid-count or in LAP):
  - Immediately forces state IDLE, count 0, lap_reg 0, and s1/s2/s3 to 0.
  - Outputs: disp_bcd = 0, running = 0, lap_active = 0, wrap = 0.
- First tick after reset release: if tick_in is already high at release, s3 = 0 gives one tick_evt. It is harmless because the state is IDLE.

## Timing
- tick_in rising edge first sampled at edge k: s2 = 1 after k+1, and the count updates at edge k+2. Latency is 2–3 clk cycles from tick_in.
- Button pulse high at edge k: state, lap_reg and clear-zeroing take effect at edge k. Outputs reflect the change in the same cycle after k.
- wrap is high for exactly the one cycle following the rollover edge.
- With clk = 50 MHz and tick_in = 100 Hz, the count advances every 500 000 clk cycles. Benches may drive tick_in faster, provided the ≥2-cycle phase rule holds.

## Test plan
- Reset, start_stop, then 123 tick_in periods → disp_bcd = 0x000123 and running = 1. Each update lands 2–3 clk after its tick_in rise, and a tick_in held high 50 cycles gives one increment.
- MINUTE_LIMIT = 2: run to 02:59.99, then one more tick → disp_bcd = 0x000000 and wrap = 1 for one cycle. Also check carry cases: 00:09.99 → 0x001000 and 00:59.99 → 0x010000.
- At 00:05.00, pulse lap, then 100 ticks → disp_bcd stays 0x000500 with lap_active = 1. Pulse clear → disp_bcd = 0x000600 and the state is RUN.
- Pulse start_stop in the same cycle as a tick_evt while in RUN → the tick is counted and the state is PAUSE. Further ticks leave the count unchanged. Pulse clear → 0x000000 and the state is IDLE.
- Pulse start_stop and clear together in PAUSE → RUN, count kept. Pulse lap and clear together in RUN → LAP not entered (clear wins and is ignored in RUN).
- Assert rst_n = 0 mid-count in LAP, asynchronously between clk edges → all outputs are 0 immediately. After release, tick_in pulses leave disp_bcd = 0 until start_stop.
